// File: rtl/traffic_pkg.sv
// traffic_pkg: shared light encodings, pedestrian FSM states and a one-hot light check
package traffic_pkg;
  localparam logic [2:0] LIGHT_RED = 3'b100;
  localparam logic [2:0] LIGHT_YEL = 3'b010;
  localparam logic [2:0] LIGHT_GRN = 3'b001;
  typedef enum logic [1:0] {IDLE, WALK, FLASH, SAFE} ped_state_t;
  function automatic logic light_ok(input logic [2:0] l);
    return l == LIGHT_RED || l == LIGHT_YEL || l == LIGHT_GRN;
  endfunction
endpackage

// File: rtl/ped_btn_sync.sv
// ped_btn_sync: 2-flop synchroniser plus rising-edge detect (clk, rst_n, btn -> pulse)
module ped_btn_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);
  logic [2:0] sh;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sh <= '0;
    else sh <= {sh[1:0], btn};
  assign pulse = sh[1] && !sh[2];
endmodule

// File: rtl/ped_crossing_ctrl.sv
// ped_crossing_ctrl: pedestrian WALK/DON'T-WALK lamps and countdown slaved to the traffic light (clk, rst_n, light, ped_btn -> ped_req, walk, dont_walk, countdown, light_err)
module ped_crossing_ctrl
  import traffic_pkg::*;
#(
  parameter int TICK_DIV    = 10,
  parameter int WALK_TICKS  = 8,
  parameter int FLASH_TICKS = 6,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       light,
  input  logic             ped_btn,
  output logic             ped_req,
  output logic             walk,
  output logic             dont_walk,
  output logic [CNT_W-1:0] countdown,
  output logic             light_err
);
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam int WW = WALK_TICKS > 1 ? $clog2(WALK_TICKS) : 1;
  ped_state_t state, state_n;
  logic [PW-1:0] presc, presc_n;
  logic [WW-1:0] wcnt, wcnt_n;
  logic [CNT_W-1:0] cnt_n;
  logic red_q, pending, pending_n, walk_n, dw_n;
  logic btn_pulse, valid, red_entry, tick, enter;
  ped_btn_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (ped_btn),
    .pulse (btn_pulse)
  );
  assign valid     = light_ok(light);
  assign red_entry = light == LIGHT_RED && !red_q;
  assign tick      = presc == PW'(TICK_DIV - 1);
  assign ped_req   = pending;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      presc     <= '0;
      wcnt      <= '0;
      countdown <= '0;
      red_q     <= 1'b0;
      pending   <= 1'b0;
      walk      <= 1'b0;
      dont_walk <= 1'b1;
      light_err <= 1'b0;
    end else begin
      state     <= state_n;
      presc     <= presc_n;
      wcnt      <= wcnt_n;
      countdown <= cnt_n;
      red_q     <= light[2];
      pending   <= pending_n;
      walk      <= walk_n;
      dont_walk <= dw_n;
      light_err <= !valid;
    end
  // An invalid bus overrides everything; a valid non-red light aborts any crossing.
  always_comb begin
    state_n = state;
    if (!valid) state_n = SAFE;
    else
      case (state)
        IDLE:    state_n = pending && red_entry ? WALK : IDLE;
        WALK:    state_n = light != LIGHT_RED ? IDLE :
                           tick && wcnt == WW'(WALK_TICKS - 1) ? FLASH : WALK;
        FLASH:   state_n = light != LIGHT_RED || (tick && countdown == '0) ? IDLE : FLASH;
        default: state_n = IDLE;
      endcase
  end
  // Outputs are computed from the next state so every lamp changes on the same edge as the FSM.
  always_comb begin
    enter     = state_n != state;
    presc_n   = (enter && (state_n == WALK || state_n == FLASH)) || tick ? '0 : presc + 1'b1;
    wcnt_n    = state_n != WALK || enter ? '0 : tick ? wcnt + 1'b1 : wcnt;
    cnt_n     = state_n != FLASH ? '0 : enter ? CNT_W'(FLASH_TICKS - 1) :
                tick ? countdown - 1'b1 : countdown;
    walk_n    = state_n == WALK;
    dw_n      = state_n != FLASH ? !walk_n : enter ? 1'b1 : tick ? !dont_walk : dont_walk;
    // A press landing on the grant cycle is kept for the following red.
    pending_n = state == IDLE && state_n == WALK ? btn_pulse :
                pending || (btn_pulse && state != WALK);
  end
endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// tb_ped_crossing_ctrl: directed self-checking bench for ped_crossing_ctrl
module tb_ped_crossing_ctrl;
  import traffic_pkg::*;
  logic clk = 1'b0;
  logic rst_n, ped_btn, ped_req, walk, dont_walk, light_err;
  logic [2:0] light;
  logic [3:0] countdown;
  int total = 0;
  int bad = 0;
  int whigh = 0;
  int n;
  ped_crossing_ctrl #(.TICK_DIV(10), .WALK_TICKS(8), .FLASH_TICKS(6), .CNT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .light     (light),
    .ped_btn   (ped_btn),
    .ped_req   (ped_req),
    .walk      (walk),
    .dont_walk (dont_walk),
    .countdown (countdown),
    .light_err (light_err)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic run(input int k);
    repeat (k) begin
      @(negedge clk);
      whigh += int'(walk);
    end
  endtask
  task automatic press3();
    ped_btn = 1'b1;
    repeat (3) @(negedge clk);
    ped_btn = 1'b0;
  endtask
  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  initial begin
    rst_n = 1'b0;
    light = LIGHT_GRN;
    ped_btn = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("rst_walk", walk, 0);
      check("rst_dw", dont_walk, 1);
      check("rst_req", ped_req, 0);
      check("rst_cd", countdown, 0);
      check("rst_err", light_err, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    ped_btn = 1'b1;
    @(negedge clk); check("req_e1", ped_req, 0);
    @(negedge clk); check("req_e2", ped_req, 0);
    @(negedge clk); check("req_e3", ped_req, 1);
    ped_btn = 1'b0;
    light = LIGHT_YEL;
    repeat (3) @(negedge clk);
    check("yel_walk", walk, 0);
    light = LIGHT_RED;
    @(negedge clk);
    check("grant_walk", walk, 1);
    check("grant_dw", dont_walk, 0);
    check("grant_req", ped_req, 0);
    check("grant_cd", countdown, 0);
    n = 0;
    while (walk === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("walk_len", n, 80);
    for (int j = 0; j < 60; j++) begin
      check("flash_cd", countdown, 5 - j / 10);
      check("flash_dw", dont_walk, (j / 10) % 2 == 0);
      check("flash_walk", walk, 0);
      @(negedge clk);
    end
    check("end_cd", countdown, 0);
    check("end_dw", dont_walk, 1);
    check("end_walk", walk, 0);
    whigh = 0;
    repeat (2) begin
      light = LIGHT_GRN; run(5);
      light = LIGHT_YEL; run(5);
      light = LIGHT_RED; run(20);
    end
    check("nopress_walk", whigh, 0);
    light = LIGHT_GRN;
    press3();
    check("p4_req", ped_req, 1);
    light = LIGHT_RED;
    repeat (81) @(negedge clk);
    check("p4_flash_cd", countdown, 5);
    check("p4_flash_walk", walk, 0);
    press3();
    check("p4_req_flash", ped_req, 1);
    repeat (57) @(negedge clk);
    check("p4_idle_req", ped_req, 1);
    check("p4_idle_cd", countdown, 0);
    check("p4_idle_dw", dont_walk, 1);
    whigh = 0;
    run(20);
    check("p4_midred_walk", whigh, 0);
    light = LIGHT_GRN;
    run(5);
    check("p4_grn_walk", whigh, 0);
    light = LIGHT_RED;
    @(negedge clk);
    check("p4_grant_walk", walk, 1);
    check("p4_grant_req", ped_req, 0);
    repeat (19) @(negedge clk);
    check("p5_walk20", walk, 1);
    light = LIGHT_GRN;
    @(negedge clk);
    check("p5_walk", walk, 0);
    check("p5_dw", dont_walk, 1);
    check("p5_cd", countdown, 0);
    check("p5_err", light_err, 0);
    check("p5_req", ped_req, 0);
    press3();
    light = LIGHT_RED;
    repeat (10) @(negedge clk);
    check("p6_walk", walk, 1);
    light = 3'b110;
    ped_btn = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("p6_err", light_err, 1);
      check("p6_walk_off", walk, 0);
      check("p6_dw", dont_walk, 1);
    end
    ped_btn = 1'b0;
    light = LIGHT_GRN;
    @(negedge clk);
    check("p6_err_clr", light_err, 0);
    check("p6_req", ped_req, 1);
    light = LIGHT_YEL;
    repeat (3) @(negedge clk);
    check("p6_yel_walk", walk, 0);
    light = LIGHT_RED;
    @(negedge clk);
    check("p6_grant_walk", walk, 1);
    check("p6_grant_req", ped_req, 0);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_walk", walk, 0);
    check("arst_dw", dont_walk, 1);
    check("arst_req", ped_req, 0);
    check("arst_cd", countdown, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_walk", walk, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
